encode16x4_queue: RTL

ENCODE16X4_QUEUE -- requirements
Module: encode16x4_queue

---
 rtl/encode16x4_queue.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/encode16x4_queue.sv
// ---------------------------------------------------------------------------
// encode16x4_queue
//
// Collects requests on 16 input lines into a pending register and hands them
// out one at a time as 4-bit binary codes through a valid/ready output stage.
// A request line held high over several cycles is merged into one pending
// bit. The granted bit stays pending until the consumer accepts it.
//
// Ports:
//   clk          - single clock, all state changes on the rising edge
//   rst          - asynchronous, active-high reset
//   in[15:0]     - request lines, in[i] requests code i
//   out[3:0]     - code of the request being presented (registered)
//   out_valid    - out holds a valid code (registered)
//   out_ready    - consumer accepts out this cycle
//   pending_cnt  - number of set bits in the pending register (registered)
//
// Configuration:
//   ENCODE_ROUND_ROBIN_EN - when defined, arbitration is round-robin starting
//                           just after the last granted index; when not
//                           defined, the lowest pending index always wins.
// ---------------------------------------------------------------------------
module encode16x4_queue (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] in,
    output logic [3:0]  out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  pending_cnt
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } stateT;

    stateT       state;
    logic [15:0] pending;
    logic [3:0]  outReg;
    logic [4:0]  pendingCntReg;

    logic        handshake;
    logic        load;
    logic [15:0] clearMask;
    logic [15:0] selSet;
    logic [15:0] pendingNext;
    logic        selAny;
    logic [3:0]  selIdx;

`ifdef ENCODE_ROUND_ROBIN_EN
    logic [3:0]  rrPtr;
    logic [3:0]  searchStart;
    logic [3:0]  candIdx;
`endif

    // Counts the set bits of a 16-bit vector; result fits 0..16.
    function automatic logic [4:0] popCount16(input logic [15:0] bits);
        logic [4:0] total;
        total = 5'd0;
        for (int i = 0; i < 16; i++) begin
            total = total + 5'(bits[i]);
        end
        return total;
    endfunction

    // The handshake consumes the presented code. Its bit is removed from the
    // pending set, but a fresh request on the same line in the same cycle
    // puts it straight back (set wins). New requests never join the
    // selection in the cycle they arrive, so selection only sees the
    // pending value minus the consumed bit.
    always_comb begin
        handshake   = out_valid && out_ready;
        load        = !out_valid || handshake;
        clearMask   = handshake ? (16'h0001 << outReg) : 16'h0000;
        selSet      = pending & ~clearMask;
        pendingNext = selSet | in;
        selAny      = |selSet;
    end

`ifdef ENCODE_ROUND_ROBIN_EN
    // Round-robin search. The pointer holds the index just after the last
    // grant, but on a handshake cycle it has not been updated yet, so the
    // start point is taken from the code being consumed right now. The loop
    // walks from the farthest offset back to the nearest so the nearest hit
    // wins.
    always_comb begin
        selIdx      = 4'd0;
        candIdx     = 4'd0;
        searchStart = handshake ? (outReg + 4'd1) : rrPtr;
        for (int k = 15; k >= 0; k--) begin
            candIdx = searchStart + 4'(k);
            if (selSet[candIdx]) begin
                selIdx = candIdx;
            end
        end
    end
`else
    // Fixed priority: scanning from the top down leaves the lowest set index
    // as the final winner, so index 0 has the highest priority.
    always_comb begin
        selIdx = 4'd0;
        for (int k = 15; k >= 0; k--) begin
            if (selSet[k]) begin
                selIdx = 4'(k);
            end
        end
    end
`endif

    // Main state register. The output stage reloads whenever it is empty or
    // its code is being accepted; while stalled it holds its code even if
    // higher-priority requests arrive. An empty selection drops out_valid
    // but leaves the last code on out. Reset discards everything, including
    // any request on in during reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            pending       <= 16'h0000;
            outReg        <= 4'd0;
            pendingCntReg <= 5'd0;
`ifdef ENCODE_ROUND_ROBIN_EN
            rrPtr         <= 4'd0;
`endif
        end else begin
            pending       <= pendingNext;
            pendingCntReg <= popCount16(pendingNext);
            if (load) begin
                if (selAny) begin
                    outReg <= selIdx;
                    state  <= PRESENT;
                end else begin
                    state  <= IDLE;
                end
            end
`ifdef ENCODE_ROUND_ROBIN_EN
            if (handshake) begin
                rrPtr <= outReg + 4'd1;
            end
`endif
        end
    end

    // Outputs come straight from registers.
    assign out         = outReg;
    assign out_valid   = (state == PRESENT);
    assign pending_cnt = pendingCntReg;

endmodule
